// File: rtl/cp0_exception_sequencer.sv
// CP0 exception-entry / ERET sequencer: drains busy multi-cycle ops, pulses CP0, flushes, redirects PC.
// Optional exception-entry statistics counter enabled by defining CP0_EXC_STATS_EN.
module cp0_exception_sequencer #(
  parameter logic [31:0] EXC_VECTOR    = 32'h80000180,
  parameter int          DRAIN_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pendingexception,
  input  logic        eret,
  input  logic        busy,
  input  logic [31:0] epc,
  output logic        stall,
  output logic        flush,
  output logic        activeexception,
  output logic        eret_commit,
  output logic        pc_redirect,
  output logic [31:0] redirect_target,
  output logic        drain_timeout,
  output logic [15:0] exc_count
);

  // state  | meaning
  // IDLE   | no sequence; stall follows pendingexception so the faulting PC holds
  // DRAIN  | exception pending, waiting for busy to clear (bounded by DRAIN_TIMEOUT)
  // COMMIT | activeexception pulse, CP0 latches EPC/Cause; instruction flushed
  // VECTOR | PC redirected to EXC_VECTOR
  // ERET   | eret_commit pulse, PC redirected to epc
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAIN  = 3'd1,
    S_COMMIT = 3'd2,
    S_VECTOR = 3'd3,
    S_ERET   = 3'd4
  } state_t;

  localparam int            CW       = $clog2(DRAIN_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_TIMEOUT - 1);

  state_t        state;
  logic [CW-1:0] drain_cnt;
  logic          stall_q, flush_q, act_q, eret_q, redir_q, vec_q;
  logic          drain_last;

  assign drain_last = (state == S_DRAIN) && busy && (drain_cnt == CNT_LAST);

  // Pulse outputs are registered from the state being entered, so each lasts exactly one state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
      stall_q   <= 1'b0;
      flush_q   <= 1'b0;
      act_q     <= 1'b0;
      eret_q    <= 1'b0;
      redir_q   <= 1'b0;
      vec_q     <= 1'b0;
    end else begin
      stall_q <= 1'b0;
      flush_q <= 1'b0;
      act_q   <= 1'b0;
      eret_q  <= 1'b0;
      redir_q <= 1'b0;
      vec_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pendingexception) begin
            drain_cnt <= '0;
            stall_q   <= 1'b1;
            if (busy) begin
              state <= S_DRAIN;
            end else begin
              state   <= S_COMMIT;
              act_q   <= 1'b1;
              flush_q <= 1'b1;
            end
          end else if (eret) begin
            state   <= S_ERET;
            eret_q  <= 1'b1;
            redir_q <= 1'b1;
            flush_q <= 1'b1;
          end
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          stall_q   <= 1'b1;
          if (!busy || drain_cnt == CNT_LAST) begin
            state   <= S_COMMIT;
            act_q   <= 1'b1;
            flush_q <= 1'b1;
          end
        end
        S_COMMIT: begin
          state   <= S_VECTOR;
          redir_q <= 1'b1;
          flush_q <= 1'b1;
          vec_q   <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign stall           = stall_q | ((state == S_IDLE) && pendingexception);
  assign flush           = flush_q;
  assign activeexception = act_q;
  assign eret_commit     = eret_q;
  assign pc_redirect     = redir_q;
  assign drain_timeout   = drain_last;
  // epc is passed through live so the ERET target is the value present in the ERET cycle.
  assign redirect_target = vec_q ? EXC_VECTOR : (eret_q ? epc : 32'h0000_0000);

`ifdef CP0_EXC_STATS_EN
  logic [15:0] exc_cnt_q;
  always_ff @(posedge clk) begin
    if (!reset)
      exc_cnt_q <= 16'h0000;
    else if (state == S_COMMIT && exc_cnt_q != 16'hFFFF)
      exc_cnt_q <= exc_cnt_q + 16'h0001;
  end
  assign exc_count = exc_cnt_q;
`else
  assign exc_count = 16'h0000;
`endif

endmodule

// File: tb/tb_cp0_exception_sequencer.sv
// Directed bench for cp0_exception_sequencer: reset, direct entry, drain, drain timeout, ERET, priority.
module tb_cp0_exception_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        pendingexception;
  logic        eret;
  logic        busy;
  logic [31:0] epc;
  logic        stall, flush, activeexception, eret_commit, pc_redirect, drain_timeout;
  logic [31:0] redirect_target;
  logic [15:0] exc_count;

  int n_vec = 0;
  int n_err = 0;
  int entries = 0;

  localparam logic [31:0] VEC = 32'h80000180;

  cp0_exception_sequencer #(.EXC_VECTOR(VEC), .DRAIN_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .pendingexception(pendingexception), .eret(eret),
    .busy(busy), .epc(epc), .stall(stall), .flush(flush),
    .activeexception(activeexception), .eret_commit(eret_commit),
    .pc_redirect(pc_redirect), .redirect_target(redirect_target),
    .drain_timeout(drain_timeout), .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_count();
`ifdef CP0_EXC_STATS_EN
    return 16'(entries);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic chk_outs(input string tag, input logic st, input logic fl, input logic ae,
                          input logic ec, input logic pr, input logic [31:0] rt, input logic dt);
    chk({tag, ".stall"}, 32'(stall), 32'(st));
    chk({tag, ".flush"}, 32'(flush), 32'(fl));
    chk({tag, ".activeexception"}, 32'(activeexception), 32'(ae));
    chk({tag, ".eret_commit"}, 32'(eret_commit), 32'(ec));
    chk({tag, ".pc_redirect"}, 32'(pc_redirect), 32'(pr));
    chk({tag, ".redirect_target"}, redirect_target, rt);
    chk({tag, ".drain_timeout"}, 32'(drain_timeout), 32'(dt));
    chk({tag, ".exc_count"}, 32'(exc_count), 32'(exp_count()));
  endtask

  // Advance one clock and land mid-cycle (negedge) for driving and sampling.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; pendingexception = 1'b0; eret = 1'b0; busy = 1'b0; epc = 32'h0;
    step(); step();
    #1 chk_outs("reset", 0, 0, 0, 0, 0, 32'h0, 0);
    reset = 1'b1;
    step();
    #1 chk_outs("idle", 0, 0, 0, 0, 0, 32'h0, 0);

    // Direct entry: pending with !busy at edge k
    pendingexception = 1'b1;
    #1 chk_outs("direct.k", 1, 0, 0, 0, 0, 32'h0, 0);
    step();
    pendingexception = 1'b0;
    #1 chk_outs("direct.k1", 1, 1, 1, 0, 0, 32'h0, 0);
    entries++;
    step();
    #1 chk_outs("direct.k2", 0, 1, 0, 0, 1, VEC, 0);
    step();
    #1 chk_outs("direct.k3", 0, 0, 0, 0, 0, 32'h0, 0);

    // Drain: busy for 5 DRAIN cycles then released; pending drops mid-drain
    pendingexception = 1'b1; busy = 1'b1;
    #1 chk("drain.enter.stall", 32'(stall), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 1) pendingexception = 1'b0;
      if (i == 4) busy = 1'b0;
      #1 chk_outs($sformatf("drain.c%0d", i), 1, 0, 0, 0, 0, 32'h0, 0);
    end
    step();
    #1 chk_outs("drain.commit", 1, 1, 1, 0, 0, 32'h0, 0);
    entries++;
    step();
    #1 chk_outs("drain.vector", 0, 1, 0, 0, 1, VEC, 0);
    step();
    #1 chk_outs("drain.idle", 0, 0, 0, 0, 0, 32'h0, 0);

    // Timeout: busy stuck, 16 DRAIN cycles, drain_timeout on the last one
    pendingexception = 1'b1; busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      pendingexception = 1'b0;
      #1 chk_outs($sformatf("tmo.c%0d", i), 1, 0, 0, 0, 0, 32'h0, (i == 15));
    end
    step();
    #1 chk_outs("tmo.commit", 1, 1, 1, 0, 0, 32'h0, 0);
    entries++;
    busy = 1'b0;
    step();
    #1 chk_outs("tmo.vector", 0, 1, 0, 0, 1, VEC, 0);
    step();
    #1 chk_outs("tmo.idle", 0, 0, 0, 0, 0, 32'h0, 0);

    // ERET: target follows epc in the ERET cycle
    eret = 1'b1; epc = 32'h00400020;
    #1 chk("eret.stall", 32'(stall), 32'd0);
    step();
    eret = 1'b0;
    #1 chk_outs("eret.k1", 0, 1, 0, 1, 1, 32'h00400020, 0);
    epc = 32'h00400040;
    #1 chk("eret.live_epc", redirect_target, 32'h00400040);
    step();
    #1 chk_outs("eret.idle", 0, 0, 0, 0, 0, 32'h0, 0);

    // Exception and ERET together: exception path only
    eret = 1'b1; pendingexception = 1'b1; epc = 32'h00400020;
    step();
    eret = 1'b0; pendingexception = 1'b0;
    #1 chk_outs("prio.commit", 1, 1, 1, 0, 0, 32'h0, 0);
    entries++;
    step();
    #1 chk_outs("prio.vector", 0, 1, 0, 0, 1, VEC, 0);
    step();
    #1 chk_outs("prio.idle", 0, 0, 0, 0, 0, 32'h0, 0);

    // Reset held two cycles mid-DRAIN aborts the sequence
    pendingexception = 1'b1; busy = 1'b1;
    step(); step();
    #1 chk("rst.in_drain.stall", 32'(stall), 32'd1);
    reset = 1'b0; pendingexception = 1'b0;
    step(); step();
    entries = 0;
    #1 chk_outs("rst.mid", 0, 0, 0, 0, 0, 32'h0, 0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      #1 chk_outs($sformatf("rst.after%0d", i), 0, 0, 0, 0, 0, 32'h0, 0);
    end
    busy = 1'b0;

    // One more entry after reset to check the statistics restart
    pendingexception = 1'b1;
    step();
    pendingexception = 1'b0;
    #1 chk_outs("post.commit", 1, 1, 1, 0, 0, 32'h0, 0);
    entries++;
    step();
    #1 chk_outs("post.vector", 0, 1, 0, 0, 1, VEC, 0);
    step();
    #1 chk_outs("post.idle", 0, 0, 0, 0, 0, 32'h0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
